// File: rtl/pipeline_host_ctrl.sv
// Host-side command sequencer for the pipeline: turns one host command at a time into
// registered run/step/pc-reset and program-port strobes, then returns a one-cycle response.
module pipeline_host_ctrl #(
  parameter int IMEM_AW = 9,
  parameter int DMEM_AW = 8,
  parameter int DMEM_DW = 64,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [2:0]         cmd_op,
  input  logic [IMEM_AW-1:0] cmd_addr,
  input  logic [DMEM_DW-1:0] cmd_wdata,
  input  logic [CNT_W-1:0]   cmd_count,
  input  logic               abort,
  output logic               rsp_valid,
  output logic               rsp_err,
  output logic [DMEM_DW-1:0] rsp_data,
  output logic               busy,
  output logic               run,
  output logic               step,
  output logic               pc_reset_pulse,
  output logic               imem_prog_we,
  output logic [IMEM_AW-1:0] imem_prog_addr,
  output logic [31:0]        imem_prog_wdata,
  output logic               dmem_prog_en,
  output logic               dmem_prog_we,
  output logic [DMEM_AW-1:0] dmem_prog_addr,
  output logic [DMEM_DW-1:0] dmem_prog_wdata,
  input  logic [DMEM_DW-1:0] dmem_prog_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    XFER    = 3'd1,
    RD_WAIT = 3'd2,
    RUNNING = 3'd3,
    RSP     = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_IMEM_WR = 3'd1,
    OP_DMEM_WR = 3'd2,
    OP_DMEM_RD = 3'd3,
    OP_PC_RST  = 3'd4,
    OP_RUN     = 3'd5,
    OP_STEP    = 3'd6,
    OP_RSVD    = 3'd7
  } op_e;

  state_e               r_state, w_state_nxt;
  logic [2:0]           r_op, w_op_nxt;
  logic [CNT_W-1:0]     r_count, w_count_nxt;
  logic [CNT_W-1:0]     r_tally, w_tally_nxt, w_tally_inc;

  logic                 r_cmd_ready, w_cmd_ready_nxt;
  logic                 r_rsp_valid, w_rsp_valid_nxt;
  logic                 r_rsp_err, w_rsp_err_nxt;
  logic [DMEM_DW-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic                 r_run, w_run_nxt;
  logic                 r_step, w_step_nxt;
  logic                 r_pc_reset, w_pc_reset_nxt;
  logic                 r_imem_we, w_imem_we_nxt;
  logic [IMEM_AW-1:0]   r_imem_addr, w_imem_addr_nxt;
  logic [31:0]          r_imem_wdata, w_imem_wdata_nxt;
  logic                 r_dmem_en, w_dmem_en_nxt;
  logic                 r_dmem_we, w_dmem_we_nxt;
  logic [DMEM_AW-1:0]   r_dmem_addr, w_dmem_addr_nxt;
  logic [DMEM_DW-1:0]   r_dmem_wdata, w_dmem_wdata_nxt;

  // Executed-cycle tally saturates so a free run never wraps back to a small number.
  assign w_tally_inc = (r_tally == {CNT_W{1'b1}}) ? r_tally : r_tally + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_count_nxt      = r_count;
    w_tally_nxt      = r_tally;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_err_nxt    = 1'b0;
    w_rsp_data_nxt   = r_rsp_data;
    w_run_nxt        = 1'b0;
    w_step_nxt       = 1'b0;
    w_pc_reset_nxt   = 1'b0;
    w_imem_we_nxt    = 1'b0;
    w_imem_addr_nxt  = '0;
    w_imem_wdata_nxt = '0;
    w_dmem_en_nxt    = 1'b0;
    w_dmem_we_nxt    = 1'b0;
    w_dmem_addr_nxt  = '0;
    w_dmem_wdata_nxt = '0;

    case (r_state)
      IDLE: begin
        // Strobes are launched on the accept edge itself, so they come straight from cmd_*.
        if (cmd_valid) begin
          w_op_nxt    = cmd_op;
          w_count_nxt = cmd_count;
          w_tally_nxt = '0;
          w_state_nxt = XFER;
          case (cmd_op)
            OP_IMEM_WR: begin
              w_imem_we_nxt    = 1'b1;
              w_imem_addr_nxt  = cmd_addr;
              w_imem_wdata_nxt = cmd_wdata[31:0];
            end
            OP_DMEM_WR: begin
              w_dmem_en_nxt    = 1'b1;
              w_dmem_we_nxt    = 1'b1;
              w_dmem_addr_nxt  = cmd_addr[DMEM_AW-1:0];
              w_dmem_wdata_nxt = cmd_wdata;
            end
            OP_DMEM_RD: begin
              w_dmem_en_nxt   = 1'b1;
              w_dmem_addr_nxt = cmd_addr[DMEM_AW-1:0];
            end
            OP_PC_RST: w_pc_reset_nxt = 1'b1;
            OP_STEP:   w_step_nxt     = 1'b1;
            OP_RUN: begin
              w_state_nxt = RUNNING;
              w_run_nxt   = 1'b1;
            end
            OP_RSVD: begin
              w_state_nxt     = RSP;
              w_rsp_valid_nxt = 1'b1;
              w_rsp_err_nxt   = 1'b1;
              w_rsp_data_nxt  = '0;
            end
            default: ;
          endcase
        end
      end
      XFER: begin
        if (r_op == OP_DMEM_RD) begin
          w_state_nxt = RD_WAIT;
        end else begin
          w_state_nxt     = RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = '0;
        end
      end
      RD_WAIT: begin
        w_state_nxt     = RSP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_data_nxt  = dmem_prog_rdata;
      end
      RUNNING: begin
        // Abort wins over the count match; a zero count only ends on abort.
        w_tally_nxt = w_tally_inc;
        if (abort || ((r_count != '0) && (w_tally_inc == r_count))) begin
          w_state_nxt     = RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_data_nxt  = DMEM_DW'(w_tally_inc);
        end else begin
          w_run_nxt = 1'b1;
        end
      end
      RSP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign w_cmd_ready_nxt = (w_state_nxt == IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op         <= '0;
      r_count      <= '0;
      r_tally      <= '0;
      r_cmd_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_rsp_data   <= '0;
      r_run        <= 1'b0;
      r_step       <= 1'b0;
      r_pc_reset   <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_dmem_en    <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
    end else begin
      r_op         <= w_op_nxt;
      r_count      <= w_count_nxt;
      r_tally      <= w_tally_nxt;
      r_cmd_ready  <= w_cmd_ready_nxt;
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_rsp_data   <= w_rsp_data_nxt;
      r_run        <= w_run_nxt;
      r_step       <= w_step_nxt;
      r_pc_reset   <= w_pc_reset_nxt;
      r_imem_we    <= w_imem_we_nxt;
      r_imem_addr  <= w_imem_addr_nxt;
      r_imem_wdata <= w_imem_wdata_nxt;
      r_dmem_en    <= w_dmem_en_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_dmem_addr  <= w_dmem_addr_nxt;
      r_dmem_wdata <= w_dmem_wdata_nxt;
    end
  end

  assign cmd_ready       = r_cmd_ready;
  assign busy            = ~r_cmd_ready;
  assign rsp_valid       = r_rsp_valid;
  assign rsp_err         = r_rsp_err;
  assign rsp_data        = r_rsp_data;
  assign run             = r_run;
  assign step            = r_step;
  assign pc_reset_pulse  = r_pc_reset;
  assign imem_prog_we    = r_imem_we;
  assign imem_prog_addr  = r_imem_addr;
  assign imem_prog_wdata = r_imem_wdata;
  assign dmem_prog_en    = r_dmem_en;
  assign dmem_prog_we    = r_dmem_we;
  assign dmem_prog_addr  = r_dmem_addr;
  assign dmem_prog_wdata = r_dmem_wdata;

endmodule
